// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port memory between instruction fetch and data access with starvation-bounded data priority.
module mips_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [SW-1:0] dmStreak;
  logic winDm, winWe, grantDm;
  logic [ADDR_W-1:0] grantAddr;
  logic [SW-1:0] nextStreak;
  always_comb begin
    grantDm = dm_req && (!if_req || dmStreak < SW'(STARVE_LIMIT));
    grantAddr = (grantDm ? dm_addr : if_addr) & ~ADDR_W'(3);
    nextStreak = !(grantDm && if_req) ? '0 :
                 dmStreak == SW'(STARVE_LIMIT) ? dmStreak : dmStreak + SW'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      dmStreak <= '0;
      winDm <= 1'b0;
      winWe <= 1'b0;
      busy <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        IDLE: if (if_req || dm_req) begin
          state <= ISSUE;
          busy <= 1'b1;
          winDm <= grantDm;
          winWe <= grantDm && dm_we;
          dmStreak <= nextStreak;
          mem_en <= 1'b1;
          mem_we <= grantDm && dm_we;
          mem_addr <= grantAddr;
          mem_wdata <= grantDm ? dm_wdata : '0;
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          state <= DONE;
          if (winDm) begin
            dm_rdata <= winWe ? '0 : mem_rdata;
            dm_ack <= 1'b1;
          end else begin
            if_rdata <= mem_rdata;
            if_ack <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: scoreboard bench with a behavioural one-cycle-latency memory.
module tb_mips_mem_arbiter;
  logic clk = 0, rst = 0;
  logic if_req = 0, if_ack, dm_req = 0, dm_we = 0, dm_ack, mem_en, mem_we, busy;
  logic [31:0] if_addr = 0, if_rdata, dm_addr = 0, dm_wdata = 0, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [31:0] mem [256];
  typedef struct {bit isDm; logic [31:0] rdata;} exp_t;
  exp_t sbq[$];
  exp_t e;
  int tests = 0, fails = 0;
  mips_mem_arbiter dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    mem_rdata <= mem_en ? mem[mem_addr[9:2]] : $urandom;
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end
  always @(negedge clk) if (if_ack || dm_ack) begin
    tests++;
    if (if_ack && dm_ack) begin
      fails++;
      $display("FAIL ack_exclusive: if_ack=%b dm_ack=%b, required not both", if_ack, dm_ack);
    end else if (sbq.size() == 0) begin
      fails++;
      $display("FAIL sb_unexpected: ack with dm_ack=%b but no transaction expected", dm_ack);
    end else begin
      e = sbq.pop_front();
      if (dm_ack !== e.isDm || (dm_ack ? dm_rdata : if_rdata) !== e.rdata) begin
        fails++;
        $display("FAIL sb_order_data: got dm=%b data=%h, required dm=%b data=%h",
                 dm_ack, dm_ack ? dm_rdata : if_rdata, e.isDm, e.rdata);
      end
    end
  end
  task automatic step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    if_req = 1; dm_req = 1;
    step(); step();
    tests++;
    if ({busy, mem_en, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b mem_en=%b addr=%h acks=%b%b, required all 0", busy, mem_en, mem_addr, if_ack, dm_ack);
    end
    if_req = 0; dm_req = 0; rst = 1;
    step();
    tests++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b mem_en=%b, required 0 0", busy, mem_en);
    end
  endtask
  task automatic test_fetch();
    if_req = 1; if_addr = 32'h10;
    sbq.push_back('{1'b0, 32'h2008_0005});
    step();
    tests++;
    if (mem_en !== 1 || mem_we !== 0 || mem_addr !== 32'h10 || busy !== 1) begin
      fails++;
      $display("FAIL fetch_issue: en=%b we=%b addr=%h busy=%b, required 1 0 00000010 1", mem_en, mem_we, mem_addr, busy);
    end
    step();
    tests++;
    if (mem_en !== 0 || mem_addr !== 0 || if_ack !== 0) begin
      fails++;
      $display("FAIL fetch_wait: en=%b addr=%h ack=%b, required 0 0 0", mem_en, mem_addr, if_ack);
    end
    step();
    tests++;
    if (if_ack !== 1 || if_rdata !== 32'h2008_0005) begin
      fails++;
      $display("FAIL fetch_ack: ack=%b data=%h, required 1 20080005", if_ack, if_rdata);
    end
    if_req = 0;
    step();
    tests++;
    if (busy !== 0 || if_ack !== 0 || if_rdata !== 32'h2008_0005) begin
      fails++;
      $display("FAIL fetch_done: busy=%b ack=%b data=%h, required 0 0 20080005", busy, if_ack, if_rdata);
    end
  endtask
  task automatic test_store();
    dm_req = 1; dm_we = 1; dm_addr = 32'h47; dm_wdata = 32'hDEAD_BEEF;
    sbq.push_back('{1'b1, 32'h0});
    step();
    tests++;
    if (mem_en !== 1 || mem_we !== 1 || mem_addr !== 32'h44 || mem_wdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL store_issue: en=%b we=%b addr=%h wdata=%h, required 1 1 00000044 deadbeef", mem_en, mem_we, mem_addr, mem_wdata);
    end
    step();
    tests++;
    if (mem_we !== 0 || mem_wdata !== 0) begin
      fails++;
      $display("FAIL store_wait: we=%b wdata=%h, required 0 0", mem_we, mem_wdata);
    end
    step();
    tests++;
    if (dm_ack !== 1 || dm_rdata !== 0 || if_ack !== 0) begin
      fails++;
      $display("FAIL store_ack: dm_ack=%b rdata=%h if_ack=%b, required 1 0 0", dm_ack, dm_rdata, if_ack);
    end
    dm_req = 0; dm_we = 0;
    step();
  endtask
  task automatic test_simultaneous();
    if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h44;
    sbq.push_back('{1'b1, 32'hDEAD_BEEF});
    sbq.push_back('{1'b0, 32'h2008_0005});
    step();
    tests++;
    if (mem_en !== 1 || mem_addr !== 32'h44 || mem_we !== 0) begin
      fails++;
      $display("FAIL simul_first: en=%b addr=%h we=%b, required 1 00000044 0", mem_en, mem_addr, mem_we);
    end
    step(); step();
    tests++;
    if (dm_ack !== 1 || dm_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL simul_dm_ack: ack=%b data=%h, required 1 deadbeef", dm_ack, dm_rdata);
    end
    dm_req = 0;
    step();
    tests++;
    if (busy !== 0) begin
      fails++;
      $display("FAIL simul_gap: busy=%b, required 0", busy);
    end
    step();
    tests++;
    if (mem_en !== 1 || mem_addr !== 32'h10) begin
      fails++;
      $display("FAIL simul_second: en=%b addr=%h, required 1 00000010", mem_en, mem_addr);
    end
    step(); step();
    tests++;
    if (if_ack !== 1 || dm_rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL simul_if_ack: if_ack=%b dm_rdata=%h, required 1 deadbeef", if_ack, dm_rdata);
    end
    if_req = 0;
    step();
  endtask
  task automatic test_starvation();
    logic [31:0] want;
    if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h44;
    for (int k = 0; k < 10; k++)
      sbq.push_back((k == 4 || k == 9) ? '{1'b0, 32'h2008_0005} : '{1'b1, 32'hDEAD_BEEF});
    for (int i = 1; i < 40; i++) begin
      step();
      if (i % 4 == 1) begin
        want = (i / 4 == 4 || i / 4 == 9) ? 32'h10 : 32'h44;
        tests++;
        if (mem_en !== 1 || mem_addr !== want) begin
          fails++;
          $display("FAIL starve_grant%0d: en=%b addr=%h, required 1 %h", i / 4, mem_en, mem_addr, want);
        end
      end
    end
    if_req = 0; dm_req = 0;
    step();
  endtask
  task automatic test_reset_mid();
    dm_req = 1; dm_we = 0; dm_addr = 32'h44;
    step(); step();
    rst = 0;
    step();
    tests++;
    if ({busy, mem_en, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_rdata, dm_rdata} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: busy=%b dm_ack=%b if_rdata=%h dm_rdata=%h, required all 0", busy, dm_ack, if_rdata, dm_rdata);
    end
    rst = 1;
    sbq.push_back('{1'b1, 32'hDEAD_BEEF});
    step();
    tests++;
    if (mem_en !== 1 || mem_addr !== 32'h44) begin
      fails++;
      $display("FAIL midreset_resample: en=%b addr=%h, required 1 00000044", mem_en, mem_addr);
    end
    step(); step();
    tests++;
    if (dm_ack !== 1) begin
      fails++;
      $display("FAIL midreset_ack: dm_ack=%b, required 1", dm_ack);
    end
    dm_req = 0;
    step();
  endtask
  task automatic test_back_to_back();
    if_req = 1; if_addr = 32'h13;
    sbq.push_back('{1'b0, 32'h2008_0005});
    sbq.push_back('{1'b0, 32'h2008_0005});
    for (int i = 1; i < 8; i++) begin
      step();
      tests++;
      if (mem_en !== (i == 1 || i == 5)) begin
        fails++;
        $display("FAIL b2b_mem_en_c%0d: en=%b, required %b", i, mem_en, i == 1 || i == 5);
      end
    end
    if_req = 0;
    step();
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h2008_0005;
    step();
    test_reset();
    test_fetch();
    test_store();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    step();
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d transactions outstanding, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
